// File: rtl/timer_run_ctrl.sv
// ---------------------------------------------------------------------------
// timer_run_ctrl
//   Run controller for the 4-digit countdown timer. It divides the system
//   clock into a count-enable tick, clamps and latches the preset, and runs
//   an IDLE/RUN/PAUSE/EXPIRED FSM from one-cycle user strobes. When the
//   count reaches zero it raises a timed alarm.
//
// Ports
//   i_CLK          system clock, rising edge
//   i_RST_N        asynchronous active-low reset
//   i_Start        strobe: start / resume counting
//   i_Stop         strobe: pause / acknowledge alarm
//   i_Load         strobe: latch i_Preset, return to IDLE
//   i_Preset[15:0] four BCD/hex digits, [15:12] is the MSD
//   i_Zero         datapath reports all four digits are zero
//   o_Tick         one-cycle count enable to the datapath
//   o_Load_strobe  one-cycle load enable to the datapath
//   o_Preset_val   clamped preset held for the datapath load
//   o_Alarm        high while the EXPIRED alarm window is active
//   o_State        0=IDLE 1=RUN 2=PAUSE 3=EXPIRED
// ---------------------------------------------------------------------------
module timer_run_ctrl #(
  parameter int c_TICK_DIV    = 100000,
  parameter int c_ALARM_TICKS = 3000,
  parameter int c_HEX_DEC     = 9
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_Start,
  input  logic        i_Stop,
  input  logic        i_Load,
  input  logic [15:0] i_Preset,
  input  logic        i_Zero,
  output logic        o_Tick,
  output logic        o_Load_strobe,
  output logic [15:0] o_Preset_val,
  output logic        o_Alarm,
  output logic [1:0]  o_State
);

  localparam int PW = $clog2(c_TICK_DIV);
  localparam int AW = $clog2(c_ALARM_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(c_TICK_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(c_ALARM_TICKS - 1);
  localparam logic [3:0]    DIG_MAX    = 4'(c_HEX_DEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic            tick_q, tick_d;
  logic            lds_q, lds_d;
  logic            alarm_q, alarm_d;
  logic [15:0]     preset_q, preset_d;
  logic            wrap;

  // Any digit above the mode's maximum is forced to that maximum.
  function automatic logic [15:0] clamp_preset(input logic [15:0] p);
    logic [15:0] r;
    r = p;
    for (int i = 0; i < 4; i++) begin
      if (p[i*4 +: 4] > DIG_MAX) r[i*4 +: 4] = DIG_MAX;
    end
    return r;
  endfunction

  assign wrap = (presc_q == PRESC_MAX);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    acnt_d   = acnt_q;
    tick_d   = 1'b0;
    lds_d    = 1'b0;
    alarm_d  = alarm_q;
    preset_d = preset_q;

    if (i_Load) begin
      // Load overrides every other strobe and any pending wrap.
      state_d  = S_IDLE;
      presc_d  = '0;
      acnt_d   = '0;
      alarm_d  = 1'b0;
      lds_d    = 1'b1;
      preset_d = clamp_preset(i_Preset);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_Start && !i_Zero) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (i_Stop) begin
            // Prescaler freezes, even on a wrap edge; no tick is issued.
            state_d = S_PAUSE;
          end else if (wrap) begin
            presc_d = '0;
            if (i_Zero) begin
              // Suppress the tick so the datapath never wraps past zero.
              state_d = S_EXPIRED;
              alarm_d = 1'b1;
              acnt_d  = '0;
            end else begin
              tick_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (i_Start) state_d = S_RUN;
        end
        S_EXPIRED: begin
          if (i_Stop) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
            acnt_d  = '0;
            presc_d = '0;
          end else if (wrap) begin
            presc_d = '0;
            if (acnt_q == ALARM_LAST) begin
              state_d = S_IDLE;
              alarm_d = 1'b0;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + AW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      acnt_q   <= '0;
      tick_q   <= 1'b0;
      lds_q    <= 1'b0;
      alarm_q  <= 1'b0;
      preset_q <= {4{DIG_MAX}};
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      acnt_q   <= acnt_d;
      tick_q   <= tick_d;
      lds_q    <= lds_d;
      alarm_q  <= alarm_d;
      preset_q <= preset_d;
    end
  end

  assign o_Tick        = tick_q;
  assign o_Load_strobe = lds_q;
  assign o_Preset_val  = preset_q;
  assign o_Alarm       = alarm_q;
  assign o_State       = state_q;

endmodule
